// File: rtl/ql_scan_chain_ctrl_if.sv
// ql_scan_chain_ctrl_if: host-side command, word-stream and status bundle for the scan chain sequencer
interface ql_scan_chain_ctrl_if #(parameter int WORD_W = 8);
  logic start, op, wvalid, wready, rvalid, rready, busy, done, so_parity;
  logic [WORD_W-1:0] wdata, rdata;
  modport master (output start, op, wdata, wvalid, rready, input wready, rdata, rvalid, busy, done, so_parity);
  modport slave (input start, op, wdata, wvalid, rready, output wready, rdata, rvalid, busy, done, so_parity);
endinterface

// File: rtl/ql_scan_chain_ctrl.sv
// ql_scan_chain_ctrl: streams host words bit-serially through a QL_FF scan chain, optionally capturing first.
// Optional QL_SCAN_PARITY_EN adds so_parity, the XOR of every bit shifted out.
module ql_scan_chain_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W = 8
) (
  input  logic CK,
  input  logic R,
  ql_scan_chain_ctrl_if.slave h,
  input  logic SO,
  output logic SI,
  output logic SE,
  output logic E
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam int OW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, FLUSH, DONE} state_t;
  state_t st;
  logic [CNT_W-1:0] cnt, left;
  logic [WORD_W-1:0] in_buf, out_buf;
  logic [IW-1:0] in_cnt, take;
  logic [OW-1:0] oidx;
  logic ofull, room, xfer, shift, last_bit, word_end, load;
  assign room = !ofull || !h.rvalid || h.rready;
  assign xfer = ofull && (!h.rvalid || h.rready);
  assign shift = st == SHIFT && in_cnt != '0 && room;
  assign last_bit = cnt == CNT_W'(CHAIN_LEN - 1);
  assign word_end = oidx == OW'(WORD_W - 1) || last_bit;
  // a word may load on the same edge the previous word's last bit leaves, keeping full rate
  assign h.wready = st == SHIFT && left != '0 && (in_cnt == '0 || (in_cnt == IW'(1) && shift));
  assign load = h.wvalid && h.wready;
  assign take = (int'(left) >= WORD_W) ? IW'(WORD_W) : IW'(left);
  assign SE = st == SHIFT;
  assign E = shift || st == CAPTURE;
  assign SI = shift && in_buf[0];
  always_ff @(posedge CK or negedge R)
    if (!R) begin
      st <= IDLE;
      cnt <= '0;
      left <= '0;
      in_buf <= '0;
      in_cnt <= '0;
      out_buf <= '0;
      oidx <= '0;
      ofull <= 1'b0;
      h.rdata <= '0;
      h.rvalid <= 1'b0;
      h.busy <= 1'b0;
      h.done <= 1'b0;
    end else begin
      h.done <= st == FLUSH && h.rvalid && h.rready && !ofull;
      h.rvalid <= xfer || (h.rvalid && !h.rready);
      if (xfer) h.rdata <= out_buf;
      out_buf <= (xfer ? '0 : out_buf) | (WORD_W'(shift & SO) << oidx);
      ofull <= shift ? word_end : ofull && !xfer;
      if (load) begin
        in_buf <= h.wdata;
        in_cnt <= take;
        left <= left - CNT_W'(take);
      end else if (shift) begin
        in_buf <= in_buf >> 1;
        in_cnt <= in_cnt - IW'(1);
      end
      if (shift) begin
        oidx <= word_end ? '0 : oidx + OW'(1);
        if (cnt != CNT_W'(CHAIN_LEN)) cnt <= cnt + CNT_W'(1);
      end
      case (st)
        IDLE: if (h.start) begin
          st <= h.op ? CAPTURE : SHIFT;
          h.busy <= 1'b1;
          cnt <= '0;
          left <= CNT_W'(CHAIN_LEN);
          in_cnt <= '0;
          oidx <= '0;
          ofull <= 1'b0;
          out_buf <= '0;
        end
        CAPTURE: st <= SHIFT;
        SHIFT: if (shift && last_bit) st <= FLUSH;
        FLUSH: if (h.rvalid && h.rready && !ofull) st <= DONE;
        DONE: begin
          st <= IDLE;
          h.busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
`ifdef QL_SCAN_PARITY_EN
  logic par;
  always_ff @(posedge CK or negedge R)
    if (!R) par <= 1'b0;
    else if (st == IDLE && h.start) par <= 1'b0;
    else if (shift) par <= par ^ SO;
  assign h.so_parity = par;
`else
  assign h.so_parity = 1'b0;
`endif
endmodule
